// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and types for the I2S receiver
//
// Purpose: default sample width, receiver FSM state encoding and the stereo
// frame record carried through the output buffer.
package i2s_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_e;

  // Field width follows the package DATA_W; the top-level DATA_W parameter
  // defaults to the same value and must be kept equal to it.
  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// rtl/i2s_rx_fifo.sv - synchronous stereo frame buffer for the I2S receiver
//
// Purpose: holds up to DEPTH completed stereo frames between the
// deserialiser and the downstream stage.
// Ports:
//   sclk, rst       clock, asynchronous active-low reset
//   push_i, din_i   write request and frame; ignored when full unless a
//                   pop happens in the same cycle
//   pop_i           read request; ignored when empty
//   full_o, empty_o occupancy flags
//   head_o          oldest frame, forced to zero while empty
module i2s_rx_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          push_i,
  input  stereo_frame_t din_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output stereo_frame_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  stereo_frame_t  mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  // The extra top pointer bit tells a full buffer from an empty one when the
  // index bits coincide.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
               (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    do_pop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push is about to take.
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    head_o   = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the buffer is empty.
  always_ff @(posedge sclk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S Philips-format stereo receiver with frame buffer
//
// Purpose: deserialises ws_i/sdata_i into left/right samples, checks slot
// framing, and presents completed frames through a valid/ready interface.
// Ports:
//   sclk, rst        bit clock, asynchronous active-low reset
//   ws_i, sdata_i    word select (0 left, 1 right) and serial data, MSB first
//   ready_i          downstream accepts the head frame when valid_o is high
//   clr_err_i        clears err_sticky_o
//   left_o, right_o  head frame samples
//   valid_o          buffer holds at least one frame
//   locked_o         receiver aligned to word-select framing
//   frame_err_o      one-cycle pulse on a short or over-long slot
//   ovf_o            one-cycle pulse when a completed frame is dropped
//   err_sticky_o     latched frame_err_o/ovf_o
module i2s_rx #(
  parameter int DATA_W     = i2s_pkg::DATA_W,
  parameter int SLOT_MAX   = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              ws_i,
  input  logic              sdata_i,
  input  logic              ready_i,
  input  logic              clr_err_i,
  output logic [DATA_W-1:0] left_o,
  output logic [DATA_W-1:0] right_o,
  output logic              valid_o,
  output logic              locked_o,
  output logic              frame_err_o,
  output logic              ovf_o,
  output logic              err_sticky_o
);

  import i2s_pkg::*;

  localparam int               CNT_W    = $clog2(SLOT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_MAX);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_W);

  rx_state_e         state_q, state_d;
  logic              ws_q, ws_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic              frame_err_q, frame_err_d;
  logic              ovf_q, ovf_d;
  logic              sticky_q, sticky_d;

  logic              ws_edge, ws_fall, ws_rise;
  logic              legal, timeout;
  logic [DATA_W-1:0] word;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  stereo_frame_t     push_frame, head;

  always_comb begin
    ws_d    = ws_i;
    ws_edge = (ws_i != ws_q);
    ws_fall = ws_edge && ws_q;
    ws_rise = ws_edge && !ws_q;

    // At a closing edge bit_cnt_q is the index of the bit on sdata_i, so the
    // slot length is bit_cnt_q + 1.
    legal   = (bit_cnt_q >= LAST_IDX);
    // Counting into SLOT_MAX without an edge means the slot ran too long.
    timeout = !ws_edge && (bit_cnt_q == CNT_MAX - CNT_ONE);
    // For a slot of exactly DATA_W bits the LSB is still on the wire.
    word    = (bit_cnt_q <= LAST_IDX) ? {shift_q[DATA_W-2:0], sdata_i} : shift_q;

    if (ws_edge) begin
      bit_cnt_d = '0;
    end else if (bit_cnt_q == CNT_MAX) begin
      bit_cnt_d = bit_cnt_q;
    end else begin
      bit_cnt_d = bit_cnt_q + CNT_ONE;
    end

    shift_d = shift_q;
    if (ws_edge) begin
      shift_d = '0;
    end else if (bit_cnt_q < DATA_LEN) begin
      shift_d = {shift_q[DATA_W-2:0], sdata_i};
    end

    state_d     = state_q;
    left_d      = left_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      SYNC: begin
        if (ws_fall) begin
          state_d = LEFT;
        end
      end
      LEFT: begin
        if (ws_rise) begin
          if (legal) begin
            left_d  = word;
            state_d = RIGHT;
          end else begin
            frame_err_d = 1'b1;
            state_d     = SYNC;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = SYNC;
        end
      end
      RIGHT: begin
        if (ws_fall) begin
          // The fall opens the next left slot whether or not this frame is kept.
          push        = legal;
          frame_err_d = !legal;
          state_d     = LEFT;
        end else if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase

    push_frame.left  = left_q;
    push_frame.right = word;

    pop      = !fifo_empty && ready_i;
    ovf_d    = push && fifo_full && !pop;
    // A new error wins over a simultaneous clear.
    sticky_d = (frame_err_d || ovf_d) ? 1'b1 : (clr_err_i ? 1'b0 : sticky_q);
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q     <= SYNC;
      ws_q        <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_q      <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
    end
  end

  i2s_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sclk    (sclk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_frame),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign left_o       = head.left;
  assign right_o      = head.right;
  assign valid_o      = !fifo_empty;
  assign locked_o     = (state_q != SYNC);
  assign frame_err_o  = frame_err_q;
  assign ovf_o        = ovf_q;
  assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - scoreboard bench for the I2S receiver
module tb_i2s_rx;

  localparam int DATA_W     = 16;
  localparam int SLOT_MAX   = 32;
  localparam int FIFO_DEPTH = 2;

  logic              sclk = 1'b0;
  logic              rst;
  logic              ws_i;
  logic              sdata_i;
  logic              ready_i;
  logic              clr_err_i;
  logic [DATA_W-1:0] left_o;
  logic [DATA_W-1:0] right_o;
  logic              valid_o;
  logic              locked_o;
  logic              frame_err_o;
  logic              ovf_o;
  logic              err_sticky_o;

  int vectors     = 0;
  int miscompares = 0;
  int fe_cnt      = 0;
  int ovf_cnt     = 0;

  logic          carry = 1'b0;
  logic [31:0]   exp_q [$];
  logic [31:0]   mon_exp;

  always #5 sclk = ~sclk;

  i2s_rx #(
    .DATA_W     (DATA_W),
    .SLOT_MAX   (SLOT_MAX),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .sclk         (sclk),
    .rst          (rst),
    .ws_i         (ws_i),
    .sdata_i      (sdata_i),
    .ready_i      (ready_i),
    .clr_err_i    (clr_err_i),
    .left_o       (left_o),
    .right_o      (right_o),
    .valid_o      (valid_o),
    .locked_o     (locked_o),
    .frame_err_o  (frame_err_o),
    .ovf_o        (ovf_o),
    .err_sticky_o (err_sticky_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic ws, input logic d);
    ws_i    = ws;
    sdata_i = d;
    @(negedge sclk);
  endtask

  // One slot of len cycles at word-select level ws. Transmission order k:
  // the first DATA_W bits are the sample MSB first, the rest random or ones.
  // Data lags ws by one cycle, so the slot's last bit rides on the next
  // slot's first cycle.
  task automatic send_slot(input logic ws, input int len, input logic [DATA_W-1:0] w,
                           input logic ones);
    logic [63:0] bits;
    bits = {$urandom, $urandom};
    if (ones) bits = '1;
    for (int k = 0; k < DATA_W; k++) bits[k] = w[DATA_W-1-k];
    cyc(ws, carry);
    for (int k = 0; k < len - 1; k++) cyc(ws, bits[k]);
    carry = bits[len-1];
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input int ll, input int lr, input logic ones,
                            input logic expect_it);
    send_slot(1'b0, ll, l, ones);
    send_slot(1'b1, lr, r, ones);
    if (expect_it) exp_q.push_back({l, r});
  endtask

  // Monitor: counts pulses and pops the scoreboard on every accepted frame.
  initial begin
    forever begin
      @(negedge sclk);
      #1;
      if (frame_err_o) fe_cnt++;
      if (ovf_o) ovf_cnt++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got %0h, want no frame", {left_o, right_o});
        end else begin
          mon_exp = exp_q.pop_front();
          check("frame", {left_o, right_o}, mon_exp);
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] a_l, a_r, b_l, b_r, c_l, c_r, d_l, d_r;
    rst       = 1'b0;
    ws_i      = 1'b0;
    sdata_i   = 1'b0;
    ready_i   = 1'b1;
    clr_err_i = 1'b0;
    repeat (3) @(negedge sclk);
    check("rst_left", left_o, 0);
    check("rst_right", right_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_locked", locked_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_sticky", err_sticky_o, 0);
    rst = 1'b1;

    // 32-cycle frames; the first one precedes the first fall and is ignored.
    send_frame(16'hdead, 16'hbeef, 16, 16, 1'b0, 1'b0);
    check("locked_before_fall", locked_o, 0);
    send_slot(1'b0, 16, 16'hdead, 1'b0);
    check("locked_after_fall", locked_o, 1);
    send_slot(1'b1, 16, 16'hbeef, 1'b0);
    exp_q.push_back({16'hdead, 16'hbeef});
    send_frame(16'hdead, 16'hbeef, 16, 16, 1'b0, 1'b1);

    // Random legal slot lengths and data.
    repeat (8) begin
      send_frame(DATA_W'($urandom), DATA_W'($urandom), $urandom_range(16, 32),
                 $urandom_range(16, 32), 1'b0, 1'b1);
    end
    // 64-cycle frame with trailing ones past the sample bits.
    send_frame(16'hbeef, 16'hdead, 32, 32, 1'b1, 1'b1);

    // Short right slot: frame discarded, error flagged, next frame fine.
    send_slot(1'b0, 16, DATA_W'($urandom), 1'b0);
    check("no_err_legal_frames", fe_cnt, 0);
    send_slot(1'b1, 12, DATA_W'($urandom), 1'b0);
    a_l = DATA_W'($urandom);
    a_r = DATA_W'($urandom);
    send_slot(1'b0, 16, a_l, 1'b0);
    check("short_slot_err", fe_cnt, 1);
    check("short_slot_sticky", err_sticky_o, 1);
    check("short_slot_locked", locked_o, 1);
    send_slot(1'b1, 16, a_r, 1'b0);
    exp_q.push_back({a_l, a_r});

    // Over-long left slot drops lock; clear is applied during it before the
    // timeout, so the timeout re-sets the sticky flag.
    clr_err_i = 1'b1;
    send_slot(1'b0, 20, DATA_W'($urandom), 1'b0);
    clr_err_i = 1'b0;
    check("sticky_cleared", err_sticky_o, 0);
    send_slot(1'b0, 20, DATA_W'($urandom), 1'b0);
    check("timeout_err", fe_cnt, 2);
    check("timeout_unlocked", locked_o, 0);
    check("timeout_sticky", err_sticky_o, 1);
    clr_err_i = 1'b1;
    send_slot(1'b1, 16, DATA_W'($urandom), 1'b0);
    clr_err_i = 1'b0;
    check("rise_in_sync_unlocked", locked_o, 0);
    check("sticky_cleared_2", err_sticky_o, 0);
    b_l = DATA_W'($urandom);
    b_r = DATA_W'($urandom);
    send_slot(1'b0, 16, b_l, 1'b0);
    check("relocked", locked_o, 1);
    send_slot(1'b1, 16, b_r, 1'b0);
    exp_q.push_back({b_l, b_r});

    // Overflow: stall for three frames, third is dropped.
    a_l = DATA_W'($urandom); a_r = DATA_W'($urandom);
    b_l = DATA_W'($urandom); b_r = DATA_W'($urandom);
    c_l = DATA_W'($urandom); c_r = DATA_W'($urandom);
    d_l = DATA_W'($urandom); d_r = DATA_W'($urandom);
    send_slot(1'b0, 16, a_l, 1'b0);
    ready_i = 1'b0;
    send_slot(1'b1, 16, a_r, 1'b0);
    exp_q.push_back({a_l, a_r});
    send_frame(b_l, b_r, 16, 16, 1'b0, 1'b1);
    send_frame(c_l, c_r, 16, 16, 1'b0, 1'b0);
    send_slot(1'b0, 16, d_l, 1'b0);
    check("ovf_count", ovf_cnt, 1);
    check("ovf_valid", valid_o, 1);
    check("ovf_sticky", err_sticky_o, 1);
    check("head_while_stalled", {left_o, right_o}, {a_l, a_r});
    ready_i = 1'b1;
    send_slot(1'b1, 16, d_r, 1'b0);
    exp_q.push_back({d_l, d_r});

    // Asynchronous reset in the middle of a right slot with a frame buffered.
    ready_i = 1'b0;
    send_slot(1'b0, 16, DATA_W'($urandom), 1'b0);
    cyc(1'b1, carry);
    repeat (5) cyc(1'b1, 1'($urandom));
    check("pre_rst_valid", valid_o, 1);
    check("pre_rst_sticky", err_sticky_o, 1);
    #3 rst = 1'b0;
    #1;
    check("async_rst_valid", valid_o, 0);
    check("async_rst_left", left_o, 0);
    check("async_rst_right", right_o, 0);
    check("async_rst_locked", locked_o, 0);
    check("async_rst_sticky", err_sticky_o, 0);
    exp_q.delete();
    @(negedge sclk);
    @(negedge sclk);
    rst     = 1'b1;
    ready_i = 1'b1;
    repeat (6) cyc(1'b1, 1'($urandom));
    check("post_rst_unlocked", locked_o, 0);
    a_l = DATA_W'($urandom);
    a_r = DATA_W'($urandom);
    send_slot(1'b0, 16, a_l, 1'b0);
    check("post_rst_locked", locked_o, 1);
    send_slot(1'b1, 16, a_r, 1'b0);
    exp_q.push_back({a_l, a_r});
    send_frame(DATA_W'($urandom), DATA_W'($urandom), 24, 32, 1'b0, 1'b1);
    send_slot(1'b0, 16, DATA_W'($urandom), 1'b0);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge sclk);
    check("queue_drained", exp_q.size(), 0);
    check("total_frame_err", fe_cnt, 2);
    check("total_ovf", ovf_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Front-end I2S receiver: deserialises the Philips-format stereo stream (ws_i, sdata_i) clocked by sclk into parallel left/right samples.
- Feeds them through a valid/ready interface to the downstream modulation/effect stage.
- Detects loss of word-select framing and output overflow; buffers up to FIFO_DEPTH stereo frames.

Parameters:
- DATA_W, 16: captured sample width, MSB first.
- SLOT_MAX, 32: maximum legal slot length in sclk cycles; longer means framing lost.
- FIFO_DEPTH, 2: output frame buffer depth; power of 2, ≥2.

Ports:
- sclk  in  1  bit clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- ws_i  in  1  word select; 0 = left slot, 1 = right slot
- sdata_i  in  1  serial data, MSB first, one-bit delay after ws change
- ready_i  in  1  downstream accepts frame when valid_o && ready_i
- clr_err_i  in  1  clears err_sticky_o
- left_o  out  DATA_W  left sample of FIFO head
- right_o  out  DATA_W  right sample of FIFO head
- valid_o  out  1  FIFO non-empty
- locked_o  out  1  receiver aligned (state != SYNC)
- frame_err_o  out  1  one-cycle pulse: short or over-long slot
- ovf_o  out  1  one-cycle pulse: completed frame dropped, FIFO full
- err_sticky_o  out  1  set by any frame_err_o/ovf_o, cleared by clr_err_i

Behaviour:
- Reset is rst, asynchronous, active-low; clock is sclk.
- While rst is low:
  - state=SYNC, ws_q=0, bit_cnt=0, shift=0, FIFO empty.
  - All outputs 0: left_o/right_o=0, valid_o=0, locked_o=0, pulses 0, err_sticky_o=0.
- Assertion mid-frame discards the partial frame and all buffered frames.
- Edge detection:
  - ws_q registers ws_i each cycle.
  - edge = ws_i != ws_q; fall = edge && ws_q==1; rise = edge && ws_q==0.
- Bit indexing:
  - The cycle after an edge carries bit index 0 (MSB).
  - The edge cycle itself carries the last bit of the preceding slot.
  - Slot length L = bit_cnt+1 at the closing edge.
  - Bits with index < DATA_W shift into shift; later bits are ignored.
  - bit_cnt resets to 0 on edge, otherwise increments, saturating at SLOT_MAX.
- Word completion at a closing edge:
  - word = shift combined with the current sdata_i bit if L ≤ DATA_W.
  - Legal iff L ≥ DATA_W.
- FSM states: SYNC, LEFT, RIGHT.
  - SYNC: wait for fall, then go to LEFT. Data before the first fall is ignored, with no error.
  - LEFT, on rise: if legal, latch left word and go to RIGHT; else frame_err_o pulse, go to SYNC.
  - RIGHT, on fall: if legal, push {left, right} to FIFO and go to LEFT (the fall opens the next left slot); else frame_err_o pulse and stay in LEFT, discarding the frame.
  - LEFT/RIGHT, bit_cnt reaches SLOT_MAX with no edge: frame_err_o pulse, go to SYNC.
- Push latency: left_o/right_o/valid_o update at the same rising edge at which the closing fall is sampled (FIFO previously empty).
- FIFO rules:
  - Pop when valid_o && ready_i.
  - Push when full with no same-cycle pop: frame dropped (oldest kept), ovf_o pulse.
  - Push when full with same-cycle pop: push accepted.
  - Pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
- err_sticky_o: set has priority over a same-cycle clr_err_i.

Decomposition:
- Shared package i2s_pkg:
  - DATA_W default constant.
  - rx_state_e (SYNC/LEFT/RIGHT).
  - stereo_frame_t (struct of left, right).
- One sub-module i2s_rx_fifo:
  - Synchronous FIFO of stereo_frame_t, parameterised by FIFO_DEPTH.
  - Ports: push/pop/full/empty/head.

Test Plan:
- Reset release, then 32-cycle frames (16-bit slots) carrying left=16'hdead, right=16'hbeef, ready_i=1:
  - First frame ignored until the first fall.
  - Then locked_o=1.
  - valid_o pulses once per frame with left_o=dead, right_o=beef.
- 64-cycle frames (32-cycle slots, bits 16–31 = 1s), left=16'hbeef, right=16'hdead: outputs beef/dead, no frame_err_o.
- Right slot of only 12 cycles: frame_err_o one pulse, no push, err_sticky_o=1; next full frame received correctly; clr_err_i clears sticky.
- ws_i held at 0 for 40 cycles after lock: frame_err_o at cycle SLOT_MAX, locked_o=0; recovery after the next fall.
- ready_i=0 for 3 frames with FIFO_DEPTH=2: frames 1 and 2 kept, ovf_o pulses on frame 3; ready_i=1 then pops frames 1, 2 in order.
- rst asserted mid-right-slot: all outputs 0 immediately (asynchronous); after release, locked_o=0 until the next fall.
